rtc_field_adjust: RTL

Parametrised BCD time-field adjuster for the RTC/VGA control machine. One instance per RTC register (seconds, minutes, hours, date, month, year): UP/DOWN presses step the field in BCD with wrap between BCD_MIN and BCD_MAX. Each press writes the new value to the RTC as an address phase followed by a data phase through the shared RTC bus controller, using a req/ack handshake. Adds true BCD arithmetic, edge detection, hold-to-repeat and bus handshaking over the earlier hours-only adjuster.

---
 rtl/rtc_field_adjust.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/rtc_field_adjust.sv
// rtc_field_adjust
//   BCD time-field adjuster for one RTC register. An UP/DOWN press (or an
//   auto-repeat while held) steps the current field value by +/-1 in BCD,
//   wrapping between BCD_MIN and BCD_MAX. The result is then written to the
//   RTC as an address phase followed by a data phase, using a req/ack
//   handshake to the shared bus controller.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset
//   enable_i    field selected for editing; low aborts to IDLE on next clock
//   up_i        increment button (debounced level)
//   down_i      decrement button (debounced level)
//   cur_val_i   current field value read from the RTC (BCD)
//   bus_ack_i   bus controller accepted the current phase
//   bus_req_o   phase request, held until acked
//   bus_ad_o    0 = address phase, 1 = data phase
//   bus_wr_o    write strobe (data phase only)
//   bus_data_o  FIELD_ADDR in address phase, new value in data phase
//   new_val_o   last computed value (BCD)
//   busy_o      high in every state except IDLE
//   done_o      one-cycle pulse after the data phase is acked
module rtc_field_adjust #(
    parameter logic [7:0]  FIELD_ADDR = 8'h23,
    parameter logic [7:0]  BCD_MIN    = 8'h00,
    parameter logic [7:0]  BCD_MAX    = 8'h23,
    parameter logic [23:0] REPEAT_DLY = 24'd5_000_000,
    parameter logic [23:0] REPEAT_PER = 24'd2_500_000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic [7:0] cur_val_i,
    input  logic       bus_ack_i,
    output logic       bus_req_o,
    output logic       bus_ad_o,
    output logic       bus_wr_o,
    output logic [7:0] bus_data_o,
    output logic [7:0] new_val_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_ADDR, S_DATA, S_DONE} state_e;

    state_e      state_q;
    logic        dir_q;          // 1 = decrement
    logic        up_q, dn_q;     // previous button levels for edge detection
    logic [23:0] cnt_q, cnt_d;   // hold counter, 1 in the press cycle
    logic        rep_q, rep_d;   // first repeat already fired in this hold
    logic        req_q, ad_q, wr_q, busy_q, done_q;
    logic [7:0]  data_q, new_val_q;

    logic rise_up, rise_dn, held_one, rpt_fire, start_up, start_dn;

    assign rise_up  = up_i & ~up_q;
    assign rise_dn  = down_i & ~dn_q;
    assign held_one = enable_i & (up_i ^ down_i);

    // Hold counter: restarts at 1 on a fresh press, fires at REPEAT_DLY and
    // then every REPEAT_PER cycles. It keeps counting while busy so a fire
    // that lands mid-transaction is simply lost, not deferred.
    always_comb begin
        rpt_fire = 1'b0;
        cnt_d    = cnt_q;
        rep_d    = rep_q;
        if (!held_one) begin
            cnt_d = '0;
            rep_d = 1'b0;
        end else if (rise_up | rise_dn) begin
            cnt_d = 24'd1;
            rep_d = 1'b0;
        end else if ((REPEAT_DLY != 24'd0) &&
                     (cnt_q == (rep_q ? REPEAT_PER : REPEAT_DLY))) begin
            rpt_fire = 1'b1;
            cnt_d    = 24'd1;
            rep_d    = 1'b1;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end
    end

    assign start_up = (rise_up & ~down_i) | (rpt_fire & up_i);
    assign start_dn = (rise_dn & ~up_i)   | (rpt_fire & down_i);

    // One BCD step with wrap; any non-BCD or out-of-range input snaps to the
    // limit the user would reach first in that direction.
    function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic dn);
        logic       bad;
        logic [7:0] r;
        bad = (v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v < BCD_MIN) || (v > BCD_MAX);
        if (bad)
            r = dn ? BCD_MAX : BCD_MIN;
        else if (!dn) begin
            if (v == BCD_MAX)         r = BCD_MIN;
            else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
            else                      r = {v[7:4], v[3:0] + 4'd1};
        end else begin
            if (v == BCD_MIN)         r = BCD_MAX;
            else if (v[3:0] == 4'd0)  r = {v[7:4] - 4'd1, 4'd9};
            else                      r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            dir_q     <= 1'b0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            cnt_q     <= '0;
            rep_q     <= 1'b0;
            req_q     <= 1'b0;
            ad_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            data_q    <= 8'h00;
            new_val_q <= 8'h00;
        end else begin
            up_q   <= up_i;
            dn_q   <= down_i;
            cnt_q  <= cnt_d;
            rep_q  <= rep_d;
            done_q <= 1'b0;
            if (!enable_i) begin
                state_q <= S_IDLE;
                req_q   <= 1'b0;
                ad_q    <= 1'b0;
                wr_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start_up | start_dn) begin
                        state_q <= S_CALC;
                        dir_q   <= start_dn;
                        busy_q  <= 1'b1;
                    end
                    S_CALC: begin
                        new_val_q <= bcd_step(cur_val_i, dir_q);
                        state_q   <= S_ADDR;
                        req_q     <= 1'b1;
                        ad_q      <= 1'b0;
                        wr_q      <= 1'b0;
                        data_q    <= FIELD_ADDR;
                    end
                    S_ADDR: if (bus_ack_i) begin
                        state_q <= S_DATA;
                        ad_q    <= 1'b1;
                        wr_q    <= 1'b1;
                        data_q  <= new_val_q;
                    end
                    S_DATA: if (bus_ack_i) begin
                        state_q <= S_DONE;
                        req_q   <= 1'b0;
                        ad_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        req_q   <= 1'b0;
                        ad_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus_req_o  = req_q;
    assign bus_ad_o   = ad_q;
    assign bus_wr_o   = wr_q;
    assign bus_data_o = data_q;
    assign new_val_o  = new_val_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule
